// File: rtl/ibex_dmem_responder.sv
// ibex_dmem_responder: tagged data-memory model for the Ibex data bus.
// Responses have a fixed latency and the number of outstanding requests is capped.
module ibex_dmem_responder #(
    parameter logic [31:0] MemBase        = 32'h8000_0000,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RespLatency    = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_is_cap_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [32:0] data_wdata_i,
    input  logic        stall_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [32:0] data_rdata_o,
    output logic        data_err_o
);
    localparam int unsigned IdxW = $clog2(MemWords);

    logic [32:0]            mem [MemWords];
    logic [2:0]             cnt_q;
    logic [RespLatency-1:0] pv_q;
    logic [RespLatency-1:0] pe_q;
    logic [32:0]            pd_q [RespLatency];
    logic [32:0]            off;
    logic [IdxW-1:0]        idx;
    logic                   ok;
    logic [32:0]            rd_word;
    logic [32:0]            wr_word;

    assign data_gnt_o = rst_ni && data_req_i && !stall_i && (cnt_q < 3'(MaxOutstanding));

    // 33-bit subtraction: a borrow into bit 32 flags addresses below MemBase
    assign off     = {1'b0, data_addr_i} - {1'b0, MemBase};
    assign idx     = off[IdxW+1:2];
    assign ok      = !off[32] && (off[31:IdxW+2] == '0) && (off[1:0] == 2'b00);
    assign rd_word = mem[idx];

    always_comb begin
        wr_word[32] = data_is_cap_i && (data_be_i == 4'hF) && data_wdata_i[32];
        for (int b = 0; b < 4; b++)
            wr_word[8*b+:8] = data_be_i[b] ? data_wdata_i[8*b+:8] : rd_word[8*b+:8];
    end

    always_ff @(posedge clk_i)
        if (data_gnt_o && ok && data_we_i) mem[idx] <= wr_word;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            pv_q  <= '0;
            pe_q  <= '0;
            for (int i = 0; i < RespLatency; i++) pd_q[i] <= '0;
        end else begin
            cnt_q   <= cnt_q + 3'(data_gnt_o) - 3'(pv_q[RespLatency-1]);
            pv_q[0] <= data_gnt_o;
            pe_q[0] <= data_gnt_o && !ok;
            pd_q[0] <= (data_gnt_o && ok && !data_we_i) ?
                       {data_is_cap_i && rd_word[32], rd_word[31:0]} : 33'h0;
            for (int i = 1; i < RespLatency; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign data_rvalid_o = pv_q[RespLatency-1];
    assign data_err_o    = pe_q[RespLatency-1];
    assign data_rdata_o  = pd_q[RespLatency-1];
endmodule

// File: tb/tb_ibex_dmem_responder.sv
// tb_ibex_dmem_responder: directed and random checks of the data-memory responder
// against a queue-based response model.
module tb_ibex_dmem_responder;
    localparam logic [31:0] Base  = 32'h8000_0000;
    localparam int          Words = 1024;
    localparam int          Lat   = 2;
    localparam int          MaxO  = 2;

    logic        clk_i = 0, rst_ni = 1;
    logic        data_req_i = 0, data_is_cap_i = 0, data_we_i = 0, stall_i = 0;
    logic [3:0]  data_be_i = 0;
    logic [31:0] data_addr_i = 0;
    logic [32:0] data_wdata_i = 0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [32:0] data_rdata_o;

    always #5 clk_i = ~clk_i;

    ibex_dmem_responder #(
        .MemBase(Base), .MemWords(Words), .RespLatency(Lat), .MaxOutstanding(MaxO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_is_cap_i(data_is_cap_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .stall_i(stall_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [32:0] rdata;
    } resp_t;

    resp_t       q[$];
    logic [32:0] mm [int];
    int          checks = 0, errors = 0, cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, compare mid-cycle against the model, then advance the model.
    task automatic step(input logic req, input logic cap, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [32:0] wd, input logic st);
        logic        eg, ev, ok;
        resp_t       r;
        longint      a;
        int          idx;
        logic [32:0] w;
        data_req_i = req; data_is_cap_i = cap; data_we_i = we; data_be_i = be;
        data_addr_i = addr; data_wdata_i = wd; stall_i = st;
        #4;
        eg = req && !st && (q.size() < MaxO);
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("gnt", 33'(data_gnt_o), 33'(eg));
        chk("rvalid", 33'(data_rvalid_o), 33'(ev));
        chk("err", 33'(data_err_o), ev ? 33'(q[0].err) : 33'h0);
        chk("rdata", data_rdata_o, ev ? q[0].rdata : 33'h0);
        if (ev) void'(q.pop_front());
        if (eg) begin
            a   = longint'(addr);
            ok  = (a >= longint'(Base)) && (a < longint'(Base) + 4 * Words) && (addr % 4 == 0);
            idx = int'((a - longint'(Base)) / 4);
            r.due = cyc + Lat;
            r.err = !ok;
            r.rdata = 33'h0;
            if (ok && we) begin
                w = mm.exists(idx) ? mm[idx] : 33'h0;
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b+:8] = wd[8*b+:8];
                w[32] = cap && (be == 4'hF) && wd[32];
                mm[idx] = w;
            end else if (ok) begin
                r.rdata = {cap && mm[idx][32], mm[idx][31:0]};
            end
            q.push_back(r);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, Base, 33'h0, 0);
    endtask

    // Reset is asserted with a request pending to show that grant is held off.
    task automatic do_reset();
        rst_ni = 0; data_req_i = 1; stall_i = 0; data_we_i = 0; data_addr_i = Base;
        #4;
        chk("rst_gnt", 33'(data_gnt_o), 33'h0);
        chk("rst_rvalid", 33'(data_rvalid_o), 33'h0);
        chk("rst_err", 33'(data_err_o), 33'h0);
        chk("rst_rdata", data_rdata_o, 33'h0);
        q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1; data_req_i = 0;
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        do_reset();
        // cap write then cap read; tag survives
        step(1, 1, 1, 4'hF, 32'h8000_0010, 33'h1_DEAD_BEEF, 0);
        step(1, 1, 0, 4'hF, 32'h8000_0010, 33'h0, 0);
        idle(3);
        // byte write clears tag, then cap and non-cap reads
        step(1, 0, 1, 4'h1, 32'h8000_0010, 33'h0_0000_0055, 0);
        step(1, 1, 0, 4'hF, 32'h8000_0010, 33'h0, 0);
        idle(3);
        step(1, 1, 1, 4'hF, 32'h8000_0014, 33'h1_1234_5678, 0);
        step(1, 0, 0, 4'h3, 32'h8000_0014, 33'h0, 0);
        // empty byte enables keep data, clear tag
        step(1, 1, 1, 4'h0, 32'h8000_0014, 33'h1_FFFF_FFFF, 0);
        step(1, 1, 0, 4'hF, 32'h8000_0014, 33'h0, 0);
        idle(3);
        // address boundaries and misalignment
        step(1, 1, 0, 4'hF, 32'h7FFF_FFFC, 33'h0, 0);
        step(1, 1, 1, 4'hF, 32'h8000_0002, 33'h1_0BAD_0BAD, 0);
        idle(1);
        step(1, 1, 1, 4'hF, Base + 4 * Words - 4, 33'h1_CAFE_F00D, 0);
        step(1, 1, 1, 4'hF, Base + 4 * Words, 33'h1_0BAD_0BAD, 0);
        idle(1);
        step(1, 1, 0, 4'hF, Base + 4 * Words - 4, 33'h0, 0);
        step(1, 1, 0, 4'hF, 32'h8000_0000 + 32'h10, 33'h0, 0);
        idle(3);
        // held request throttled by the outstanding limit, then stalled
        for (int i = 0; i < 6; i++) step(1, 0, 0, 4'hF, 32'h8000_0010, 33'h0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'hF, 32'h8000_0010, 33'h0, 1);
        // reset with two in flight
        step(1, 1, 0, 4'hF, 32'h8000_0010, 33'h0, 0);
        step(1, 1, 0, 4'hF, 32'h8000_0014, 33'h0, 0);
        do_reset();
        idle(3);
        step(1, 1, 0, 4'hF, 32'h8000_0010, 33'h0, 0);
        idle(3);
        // random traffic over a preloaded window plus out-of-range addresses
        for (int i = 0; i < 16; i++)
            step(1, 1, 1, 4'hF, Base + 32'(4 * i), {1'($urandom), $urandom}, 0);
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ad;
            int          sel;
            sel = $urandom_range(0, 9);
            ad  = (sel == 0) ? 32'h7FFF_FFFC - 32'(4 * $urandom_range(0, 3)) :
                  (sel == 1) ? Base + 32'(4 * Words) + 32'($urandom_range(0, 15)) :
                  (sel < 4)  ? Base + 32'($urandom_range(0, 63)) :
                               Base + 32'(4 * $urandom_range(0, 15));
            step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), ad,
                 {1'($urandom), $urandom}, $urandom_range(0, 7) == 0);
        end
        idle(Lat + 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
